// File: rtl/tinker_dmem.sv
// -----------------------------------------------------------------------------
// tinker_dmem
//   Data memory for the Tinker core. Requests and responses use a
//   single-outstanding handshake with a fixed, parameterised latency.
//   The memory is byte-addressed and little-endian. It supports
//   1/2/4/8-byte accesses and reports errors.
//
// Parameters
//   DATA_W     data path width (32 or 64)
//   ADDR_W     byte address width
//   MEM_BYTES  storage size in bytes
//   LATENCY    cycles from the accept edge until resp_valid is sampled (>= 1)
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (req_ready low during reset)
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_size                 log2 of the access size in bytes
//   req_wdata                store data, low (1<<req_size) bytes used
//   resp_valid / resp_ready  response handshake
//   resp_rdata               zero-extended load data (0 for stores/errors)
//   resp_err                 {oversize, out_of_range, misaligned}
// -----------------------------------------------------------------------------
module tinker_dmem #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 524288,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [2:0]        resp_err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // One bit wider than the address so that addr + size cannot wrap below
    // the limit.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [2:0]          err_q;

    logic [7:0]          bytes [MEM_BYTES];

    logic                accept;
    logic [3:0]          size_bytes;
    logic [2:0]          req_err;
    logic [IDX_W-1:0]    base;
    logic [DATA_W-1:0]   load_data;

    assign req_ready  = (state_q == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign size_bytes = 4'd1 << req_size;
    assign base       = req_addr[IDX_W-1:0];

    // bit0 misaligned, bit1 out of range, bit2 wider than the data path
    assign req_err[0] = (req_addr[2:0] & (size_bytes[2:0] - 3'd1)) != 3'd0;
    assign req_err[1] = ({1'b0, req_addr} + (ADDR_W+1)'(size_bytes)) > MEM_LIMIT;
    assign req_err[2] = {size_bytes, 3'b000} > 7'(DATA_W);

    // Little-endian gather of the addressed bytes; bytes above the access
    // size stay zero.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path
        // leaves it unassigned and no latch is inferred.
        load_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (4'(i) < size_bytes) begin
                load_data[8*i +: 8] = bytes[base + IDX_W'(i)];
            end
        end
    end

    // NOTE: the storage array has no reset branch. Its contents survive
    // reset and change only on an error-free store accept.
    always_ff @(posedge clk) begin
        if (accept && req_we && (req_err == 3'b000)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (4'(i) < size_bytes) begin
                    bytes[base + IDX_W'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so every
        // register sees the values from before the edge.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 3'b000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        err_q   <= req_err;
                        rdata_q <= (!req_we && (req_err == 3'b000)) ? load_data : '0;
                        if (LATENCY > 1) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
